// File: rtl/regfile_sweep_datapath_pkg.sv
// Shared definitions for the sweep handshake: state encodings and default sizes,
// used by both this datapath and the sweep controller.
package regfile_sweep_datapath_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/regfile_sweep_datapath_regfile_bank.sv
// Register file storage: one synchronous write port and two asynchronous read
// ports (host read and sweep pointer read). Cleared by the master reset.
module regfile_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              Mrst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array: wiped on master reset, otherwise written on the host strobe.
    always_ff @(posedge clk or negedge Mrst_n) begin
        if (!Mrst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports are combinational, so a same-cycle write shows up only after the edge.
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/regfile_sweep_datapath.sv
// Datapath side of the go/rst/enable/compare sweep handshake. Walks every register
// file entry once under controller enables, accumulating sum and maximum, and
// raises compare once the last entry has been consumed.
import regfile_sweep_datapath_pkg::*;

module regfile_sweep_datapath #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     Mrst_n,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     activo,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     compare,
    output logic [DATA_W+ADDR_W-1:0] sum,
    output logic [DATA_W-1:0]        max_val,
    output logic [ADDR_W-1:0]        max_idx,
    output logic                     wr_err
);

    sweep_state_t      state;
    sweep_state_t      next_state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] cur_data;
    logic              consume;
    logic              last_entry;
    logic              write_ok;

    // Host writes are only accepted while no sweep is in progress.
    assign write_ok   = wr_en && !activo;
    assign last_entry = (ptr == ADDR_W'(DEPTH - 1));

    regfile_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .Mrst_n  (Mrst_n),
        .we      (write_ok),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr_a (rd_addr),
        .rdata_a (rd_data),
        .raddr_b (ptr),
        .rdata_b (cur_data)
    );

    // Sweep state register.
    always_ff @(posedge clk or negedge Mrst_n) begin
        if (!Mrst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and consume strobe; rst beats activo=0, which beats enable.
    always_comb begin
        next_state = state;
        consume    = 1'b0;
        if (rst) begin
            next_state = activo ? RUN : IDLE;
        end else if (!activo) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: next_state = RUN;
                RUN: begin
                    if (enable) begin
                        consume = 1'b1;
                        if (last_entry) begin
                            next_state = DONE;
                        end
                    end
                end
                DONE:    next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Pointer, accumulators and compare flag; results survive aborts and DONE exits.
    always_ff @(posedge clk or negedge Mrst_n) begin
        if (!Mrst_n) begin
            ptr     <= '0;
            sum     <= '0;
            max_val <= '0;
            max_idx <= '0;
            compare <= 1'b0;
        end else if (rst) begin
            ptr     <= '0;
            sum     <= '0;
            max_val <= '0;
            max_idx <= '0;
            compare <= 1'b0;
        end else if (!activo) begin
            compare <= 1'b0;
        end else if (consume) begin
            sum <= sum + {{ADDR_W{1'b0}}, cur_data};
            if (cur_data > max_val) begin
                max_val <= cur_data;
                max_idx <= ptr;
            end
            if (last_entry) begin
                ptr     <= '0;
                compare <= 1'b1;
            end else begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end

    // Rejected-write flag: a one-cycle pulse after a write attempted during a sweep.
    always_ff @(posedge clk or negedge Mrst_n) begin
        if (!Mrst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && activo;
        end
    end

endmodule

// File: tb/tb_regfile_sweep_datapath.sv
// Directed testbench for regfile_sweep_datapath with hand-computed expectations.
import regfile_sweep_datapath_pkg::*;

module tb_regfile_sweep_datapath;

    logic        clk;
    logic        Mrst_n;
    logic        rst;
    logic        enable;
    logic        activo;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        compare;
    logic [10:0] sum;
    logic [7:0]  max_val;
    logic [2:0]  max_idx;
    logic        wr_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] vec [8];

    regfile_sweep_datapath #(
        .DATA_W (8),
        .DEPTH  (8),
        .ADDR_W (3)
    ) dut (
        .clk     (clk),
        .Mrst_n  (Mrst_n),
        .rst     (rst),
        .enable  (enable),
        .activo  (activo),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .compare (compare),
        .sum     (sum),
        .max_val (max_val),
        .max_idx (max_idx),
        .wr_err  (wr_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and on mismatch counts and reports the failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive controller inputs and advance one clock, settling 1 ns past the edge.
    task automatic applyStimulus(input logic r, input logic a, input logic e);
        rst    = r;
        activo = a;
        enable = e;
        @(posedge clk);
        #1;
    endtask

    // Host write of one entry with activo low.
    task automatic writeEntry(input logic [2:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        applyStimulus(1'b0, 1'b0, 1'b0);
        wr_en   = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        vec = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd0, 8'd2, 8'd7, 8'd4};
        Mrst_n  = 1'b0;
        rst     = 1'b0;
        enable  = 1'b0;
        activo  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;

        #3;
        checkOutput("reset_compare", compare, 0);
        checkOutput("reset_sum",     sum,     0);
        checkOutput("reset_max_val", max_val, 0);
        checkOutput("reset_wr_err",  wr_err,  0);
        checkOutput("reset_rd_data", rd_data, 0);
        Mrst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load the register file and read one entry back.
        for (int i = 0; i < 8; i++) begin
            writeEntry(3'(i), vec[i]);
        end
        rd_addr = 3'd1;
        #1;
        checkOutput("load_rd_data1", rd_data, 9);

        // Contiguous sweep.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("sweep_clear_state", dut.state, RUN);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
        end
        checkOutput("sweep_7_compare", compare, 0);
        checkOutput("sweep_7_sum",     sum,     31);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("sweep_8_compare", compare, 1);
        checkOutput("sweep_8_sum",     sum,     35);
        checkOutput("sweep_8_max_val", max_val, 9);
        checkOutput("sweep_8_max_idx", max_idx, 1);

        // Enables in DONE are ignored.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
        end
        checkOutput("done_sum",     sum,     35);
        checkOutput("done_compare", compare, 1);
        checkOutput("done_max_idx", max_idx, 1);

        // rst together with enable: rst wins.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("rst_win_sum",     sum,     0);
        checkOutput("rst_win_compare", compare, 0);
        checkOutput("rst_win_max_val", max_val, 0);
        checkOutput("rst_win_ptr",     dut.ptr, 0);

        // Gapped sweep: compare follows the 8th enable, not the 8th clock.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        checkOutput("gap_7_compare", compare, 0);
        checkOutput("gap_7_sum",     sum,     31);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("gap_8_compare", compare, 1);
        checkOutput("gap_8_sum",     sum,     35);
        checkOutput("gap_8_max_val", max_val, 9);
        checkOutput("gap_8_max_idx", max_idx, 1);

        // Leaving DONE by dropping activo: compare falls, results held.
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("done_exit_compare", compare, 0);
        checkOutput("done_exit_sum",     sum,     35);
        checkOutput("done_exit_state",   dut.state, IDLE);

        // Write rejected while activo is high.
        rd_addr = 3'd2;
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'hAA;
        applyStimulus(1'b0, 1'b1, 1'b0);
        wr_en = 1'b0;
        checkOutput("wr_rej_err",  wr_err,  1);
        checkOutput("wr_rej_data", rd_data, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("wr_rej_err_1cyc", wr_err, 0);

        // Retry with activo low; old value visible until the edge.
        activo  = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'd5;
        #1;
        checkOutput("wr_same_cycle_old", rd_data, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        wr_en = 1'b0;
        checkOutput("wr_ok_data", rd_data, 5);
        checkOutput("wr_ok_err",  wr_err,  0);
        writeEntry(3'd2, 8'd1);

        // Abort after three enables.
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_state",   dut.state, IDLE);
        checkOutput("abort_sum",     sum,     13);
        checkOutput("abort_compare", compare, 0);
        checkOutput("abort_max_idx", max_idx, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_enable_ignored", sum, 13);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
        end
        checkOutput("resweep_sum",     sum,     35);
        checkOutput("resweep_compare", compare, 1);

        // Master reset mid-operation takes effect without a clock edge.
        rd_addr = 3'd1;
        Mrst_n  = 1'b0;
        #1;
        checkOutput("mrst_compare", compare, 0);
        checkOutput("mrst_sum",     sum,     0);
        checkOutput("mrst_max_val", max_val, 0);
        checkOutput("mrst_max_idx", max_idx, 0);
        checkOutput("mrst_rd_data", rd_data, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        Mrst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // All-zero data sweep: max stays 0 at index 0.
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
        end
        checkOutput("zero_sum",     sum,     0);
        checkOutput("zero_max_val", max_val, 0);
        checkOutput("zero_max_idx", max_idx, 0);
        checkOutput("zero_compare", compare, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
